uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter sitting directly downstream of the core's memory stage. It consumes the core's `uart_dout`/`uart_we` write strobe, queues bytes in a small FIFO and serialises them onto a TX pin at a fixed baud divisor. The core has no backpressure path, so a full FIFO drops bytes and records the loss in a sticky flag.

---
 rtl/mspu_uart_pkg.sv | 14 +
 rtl/uart_fifo.sv | 51 +++++
 rtl/uart_tx_fifo.sv | 105 ++++++++++
 tb/tb_uart_tx_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mspu_uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package mspu_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_BITS        = 8;
  localparam int UART_DEFAULT_BAUD_DIV = 868;

endpackage

// File: rtl/uart_fifo.sv
// Single-clock byte FIFO; head entry is presented combinationally on rdata.
module uart_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int         DEPTH   = 1 << AW;
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [0:DEPTH-1];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full  = (r_count == COUNT_FULL);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rptr];

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
  assign w_do_pop  = pop & ~empty & ~reset;
  assign w_do_push = push & (~full | w_do_pop) & ~reset;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by a no-backpressure write strobe.
module uart_tx_fifo
  import mspu_uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_DEFAULT_BAUD_DIV,
  parameter int FIFO_AW  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        din,
  input  logic               we,
  output logic               txd,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int               CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t   r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_txd;
  logic             r_busy;
  logic             r_overflow;

  logic [7:0]       w_rdata;
  logic [FIFO_AW:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_baud_last;
  logic             w_pop;
  logic             w_unused_din;

  assign w_unused_din = ^din[31:8];
  assign w_baud_last  = (r_baud_cnt == BAUD_LAST);
  // Pop from IDLE, or on the last stop-bit cycle so frames run back to back.
  assign w_pop = ~w_empty & ((r_state == ST_IDLE) |
                             ((r_state == ST_STOP) & w_baud_last));

  uart_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (we),
    .pop   (w_pop),
    .wdata (din[7:0]),
    .rdata (w_rdata),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (w_pop) r_shift <= w_rdata;
    else if ((r_state == ST_DATA) && w_baud_last) r_shift <= r_shift >> 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_txd  <= (r_state == ST_START) ? 1'b0 :
                (r_state == ST_DATA)  ? r_shift[0] : 1'b1;
      r_busy <= (r_state != ST_IDLE) | (w_count != '0);
      if (we & w_full & ~w_pop) r_overflow <= 1'b1;
      r_baud_cnt <= w_baud_last ? '0 : r_baud_cnt + 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_baud_cnt <= '0;
          if (w_pop) r_state <= ST_START;
        end
        ST_START: begin
          if (w_baud_last) begin
            r_state   <= ST_DATA;
            r_bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (w_baud_last) begin
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == BIT_LAST) r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_baud_last) r_state <= w_pop ? ST_START : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign txd        = r_txd;
  assign busy       = r_busy;
  assign fifo_count = w_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BAUD_DIV=4, FIFO_AW=4.
module tb_uart_tx_fifo;

  localparam int BD    = 4;
  localparam int AW    = 4;
  localparam int FRAME = 10 * BD;
  localparam int MAXC  = 1024;

  logic          clk;
  logic          reset;
  logic [31:0]   din;
  logic          we;
  logic          txd;
  logic          busy;
  logic [AW:0]   fifo_count;
  logic          overflow;

  int n_cmp;
  int n_err;

  logic          s_we  [0:MAXC-1];
  logic [31:0]   s_din [0:MAXC-1];
  int            e_cnt [0:MAXC-1];
  int            e_ovf [0:MAXC-1];
  logic [7:0]    exp_bytes[$];

  typedef struct {
    logic [31:0] din;
    logic [7:0]  exp_byte;
  } vec_t;
  vec_t tbl [6];

  uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .we         (we),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected line level after edge k when the queued bytes start on edge 2 and run contiguously.
  function automatic logic exp_txd(int k);
    int off, f, b;
    if (k < 2) return 1'b1;
    off = k - 2;
    f   = off / FRAME;
    if (f >= exp_bytes.size()) return 1'b1;
    b = (off % FRAME) / BD;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return exp_bytes[f][b-1];
  endfunction

  function automatic logic exp_busy(int k);
    return (k >= 1) && (k < 2 + FRAME * exp_bytes.size());
  endfunction

  task automatic clr();
    for (int i = 0; i < MAXC; i++) begin
      s_we[i]  = 1'b0;
      s_din[i] = 32'h0;
      e_cnt[i] = -1;
      e_ovf[i] = -1;
    end
    exp_bytes.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    we    = 1'b0;
    din   = 32'h0;
    step();
    step();
    chk("rst_txd", -1, 32'(txd), 32'd1);
    chk("rst_busy", -1, 32'(busy), 32'd0);
    chk("rst_count", -1, 32'(fifo_count), 32'd0);
    chk("rst_ovf", -1, 32'(overflow), 32'd0);
    reset = 1'b0;
  endtask

  task automatic run_seq(input int ncyc, input string tag);
    for (int k = 0; k < ncyc; k++) begin
      we  = s_we[k];
      din = s_din[k];
      step();
      chk({tag, "_txd"}, k, 32'(txd), 32'(exp_txd(k)));
      chk({tag, "_busy"}, k, 32'(busy), 32'(exp_busy(k)));
      if (e_cnt[k] >= 0) chk({tag, "_count"}, k, 32'(fifo_count), 32'(e_cnt[k]));
      if (e_ovf[k] >= 0) chk({tag, "_ovf"}, k, 32'(overflow), 32'(e_ovf[k]));
    end
    we = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    we    = 1'b0;
    din   = 32'h0;

    tbl[0] = '{32'h0000_0055, 8'h55};
    tbl[1] = '{32'hDEAD_BE5A, 8'h5A};
    tbl[2] = '{32'h0000_00FF, 8'hFF};
    tbl[3] = '{32'hFFFF_FF00, 8'h00};
    tbl[4] = '{32'h1234_5680, 8'h80};
    tbl[5] = '{32'h0000_0101, 8'h01};

    // Single-byte frames: waveform, busy window and count never above 1.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      clr();
      s_we[0]  = 1'b1;
      s_din[0] = tbl[v].din;
      exp_bytes.push_back(tbl[v].exp_byte);
      e_cnt[0] = 1;
      for (int k = 1; k < 50; k++) e_cnt[k] = 0;
      e_ovf[49] = 0;
      run_seq(50, "single");
    end

    // Three back-to-back frames.
    do_reset();
    clr();
    for (int k = 0; k < 3; k++) begin
      s_we[k]  = 1'b1;
      s_din[k] = 32'h41 + 32'(k);
    end
    exp_bytes = '{8'h41, 8'h42, 8'h43};
    e_cnt[129] = 0;
    e_ovf[129] = 0;
    run_seq(130, "b2b");

    // Overflow: 18 writes into a 16-deep FIFO with one early pop.
    do_reset();
    clr();
    for (int k = 0; k < 18; k++) begin
      s_we[k]  = 1'b1;
      s_din[k] = 32'(k);
      e_cnt[k] = (k <= 1) ? 1 : ((k < 16) ? k : 16);
    end
    for (int i = 0; i <= 16; i++) exp_bytes.push_back(8'(i));
    e_ovf[16]  = 0;
    e_ovf[17]  = 1;
    e_cnt[699] = 0;
    e_ovf[699] = 1;
    run_seq(700, "ovf");

    // Full FIFO, push coinciding with the stop-bit pop.
    do_reset();
    clr();
    for (int k = 0; k < 17; k++) begin
      s_we[k]  = 1'b1;
      s_din[k] = 32'h80 + 32'(k);
      exp_bytes.push_back(8'h80 + 8'(k));
    end
    e_cnt[16]  = 16;
    e_cnt[40]  = 16;
    s_we[41]   = 1'b1;
    s_din[41]  = 32'hC5;
    exp_bytes.push_back(8'hC5);
    e_cnt[41]  = 16;
    e_ovf[41]  = 0;
    e_cnt[42]  = 16;
    e_cnt[739] = 0;
    e_ovf[739] = 0;
    run_seq(740, "fullpp");

    // Reset during data bit 3 with five bytes queued.
    do_reset();
    clr();
    for (int k = 0; k < 6; k++) begin
      s_we[k]  = 1'b1;
      s_din[k] = 32'h11 * 32'(k);
      exp_bytes.push_back(8'h11 * 8'(k));
    end
    e_cnt[5]  = 5;
    e_cnt[18] = 5;
    // Truncate the busy model: frames are abandoned, but the bench checks busy up to edge 18 only.
    run_seq(19, "midrst");
    reset = 1'b1;
    we    = 1'b1;
    din   = 32'h77;
    step();
    chk("midrst_txd", 19, 32'(txd), 32'd1);
    chk("midrst_count", 19, 32'(fifo_count), 32'd0);
    chk("midrst_busy", 19, 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    we    = 1'b0;
    for (int k = 21; k < 81; k++) begin
      step();
      chk("postrst_txd", k, 32'(txd), 32'd1);
      chk("postrst_busy", k, 32'(busy), 32'd0);
      chk("postrst_count", k, 32'(fifo_count), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
